rst_seq_gen: RTL and testbench
==============================

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of sequenced reset channels (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: ext_rst_req synchroniser depth (2..4).
REQ-003 SHALL have parameter STRETCH_CYC, default 16: minimum reset hold after ext_rst_req is seen low (1..65535).
REQ-004 SHALL have parameter STAGGER_CYC, default 4: cycles between successive channel releases (0..65535).
REQ-005 SHALL have port sys_clk_25m, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ext_rst_req, input, 1: asynchronous active-high external reset request.
REQ-008 SHALL have port sw_rst_req, input, NUM_CH: per-channel synchronous software reset pulse.
REQ-009 SHALL have port rst_n_ch, output, NUM_CH: registered active-low channel resets.
REQ-010 SHALL have port rst_done, output, 1: high when every channel is released and no software reset is active.
REQ-011 SHALL have port busy, output, 1: high in ASSERT or RELEASE.

Function
REQ-012 SHALL synchronise ext_rst_req through SYNC_STAGES flops; the last stage is ext_rst_sync.
REQ-013 SHALL implement FSM states ASSERT, RELEASE and RUN.
REQ-014 ASSERT SHALL drive all rst_n_ch low; a counter SHALL increment on each cycle with ext_rst_sync=0 and clear on any cycle with ext_rst_sync=1.
REQ-015 When the counter reaches STRETCH_CYC, the FSM SHALL enter RELEASE and raise rst_n_ch[0] on that same edge.
REQ-016 RELEASE SHALL raise rst_n_ch[i] STAGGER_CYC cycles after rst_n_ch[i-1]; with STAGGER_CYC=0, all channels SHALL rise on the same edge.
REQ-017 After rst_n_ch[NUM_CH-1] rises, the FSM SHALL enter RUN; rst_done SHALL rise one cycle later.
REQ-018 ext_rst_sync=1 in any state SHALL force ASSERT on the next edge: all rst_n_ch low, counter cleared, rst_done low.
REQ-019 In RUN, sw_rst_req[i]=1 SHALL drive rst_n_ch[i] low on the next edge and hold it low for STRETCH_CYC cycles; other channels SHALL be unaffected.
REQ-020 A new sw_rst_req[i] during that channel's hold SHALL restart its count.
REQ-021 sw_rst_req SHALL be ignored in ASSERT and RELEASE.
REQ-022 When ext_rst_sync and sw_rst_req are high in the same cycle, ext_rst_sync SHALL win and all per-channel counters SHALL clear.
REQ-023 Counters SHALL be $clog2(max(STRETCH_CYC,STAGGER_CYC)+1) bits wide and SHALL saturate rather than wrap.
REQ-024 The ext_rst_req path to rst_n_ch low SHALL take exactly SYNC_STAGES+1 cycles.

Reset
REQ-025 On reset=1 the block SHALL load: synchroniser stages 1, state ASSERT, all counters 0, rst_n_ch all 0, rst_done 0, busy 1.
REQ-026 reset asserted mid-RELEASE or mid-software-reset SHALL restart the full sequence from ASSERT.

Configuration
REQ-027 With RST_SEQ_SW_RST_EN defined, REQ-019..REQ-022 SHALL be compiled in.
REQ-028 Without RST_SEQ_SW_RST_EN, the sw_rst_req port SHALL remain present but ignored, no per-channel counters SHALL be built, and rst_done SHALL equal (state==RUN), delayed one cycle.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the FSM state enum, default parameter constants and the counter-width function.
REQ-030 Sub-module rst_sync_chain, a parametrised SYNC_STAGES synchroniser with reset value 1, SHALL implement REQ-012.

Verification
All cases use NUM_CH=3, SYNC_STAGES=2, STRETCH_CYC=4, STAGGER_CYC=3 unless stated; edge numbers count from the first edge with reset=0.
REQ-031 Reset then release, ext_rst_req=0: rst_n_ch[0] rises at edge 6, ch1 at 9, ch2 at 12, rst_done at 13, busy falls at 12.
REQ-032 ext_rst_req pulsed high for 1 cycle at edge 8: all rst_n_ch are low by edge 11, and the sequence restarts with ch0 rising 4 cycles after ext_rst_sync falls.
REQ-033 STAGGER_CYC=0: all three channels rise together at edge 6 and rst_done rises at edge 7.
REQ-034 With RST_SEQ_SW_RST_EN in RUN, sw_rst_req=3'b010 for 1 cycle: only ch1 goes low for 4 cycles and rst_done drops for that interval; a repeat pulse at hold cycle 2 extends the low time to 6 cycles.
REQ-035 sw_rst_req and ext_rst_req high together in RUN: all channels go low, and the full sequence from REQ-031 repeats.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default parameter values and the counter-width helper.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   localparam int unsigned DEF_NUM_CH      = 3;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_STRETCH_CYC = 16;
   localparam int unsigned DEF_STAGGER_CYC = 4;

   // Wide enough to hold the larger of the two terminal counts.
   function automatic int unsigned cnt_width(input int unsigned stretch,
                                             input int unsigned stagger);
      int unsigned m;
      m = (stretch > stagger) ? stretch : stagger;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_gen_sync.sv
// rst_sync_chain: STAGES-deep flop chain for an asynchronous request; every
// stage resets to 1 so the request reads as asserted until proven quiet.
module rst_sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered reset sequencer: holds all channels low after an external
// request, then releases them one by one. Define RST_SEQ_SW_RST_EN for per-channel software resets.
module rst_seq_gen
   import rst_seq_pkg::*;
#(
   parameter int unsigned NUM_CH      = DEF_NUM_CH,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned STRETCH_CYC = DEF_STRETCH_CYC,
   parameter int unsigned STAGGER_CYC = DEF_STAGGER_CYC
) (
   input  logic              sys_clk_25m,
   input  logic              reset,
   input  logic              ext_rst_req,
   input  logic [NUM_CH-1:0] sw_rst_req,
   output logic [NUM_CH-1:0] rst_n_ch,
   output logic              rst_done,
   output logic              busy
);

   localparam int unsigned     CW        = cnt_width(STRETCH_CYC, STAGGER_CYC);
   localparam int unsigned     CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0]   STRETCH_V = CW'(STRETCH_CYC);
   localparam logic [CW-1:0]   STAGGER_V = CW'(STAGGER_CYC);
   localparam logic [CHW-1:0]  LAST_CH   = CHW'(NUM_CH - 1);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   logic              ext_rst_sync;
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic [CHW-1:0]    ch_idx_q, ch_idx_d;
   logic [NUM_CH-1:0] rst_n_q, rst_n_d, seq_rst_n_d, sw_hold;
   logic              rst_done_q, rst_done_d;

   rst_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (sys_clk_25m),
      .rst_i (reset),
      .d_i   (ext_rst_req),
      .q_o   (ext_rst_sync)
   );

   // rst_n_q doubles as the sequencer's memory of released channels, since
   // software holds only exist in RUN where the sequencer drives all ones.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_idx_d    = ch_idx_q;
      seq_rst_n_d = rst_n_q;
      cnt_inc     = sat_inc(cnt_q);
      if (ext_rst_sync) begin
         state_d     = ST_ASSERT;
         cnt_d       = '0;
         ch_idx_d    = '0;
         seq_rst_n_d = '0;
      end else begin
         unique case (state_q)
            ST_ASSERT: begin
               seq_rst_n_d = '0;
               cnt_d       = cnt_inc;
               if (cnt_inc == STRETCH_V) begin
                  cnt_d = '0;
                  if (STAGGER_CYC == 0 || NUM_CH == 1) begin
                     seq_rst_n_d = '1;
                     state_d     = ST_RUN;
                  end else begin
                     seq_rst_n_d[0] = 1'b1;
                     ch_idx_d       = CHW'(1);
                     state_d        = ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               cnt_d = cnt_inc;
               if (cnt_inc == STAGGER_V) begin
                  cnt_d                 = '0;
                  seq_rst_n_d[ch_idx_q] = 1'b1;
                  if (ch_idx_q == LAST_CH) begin
                     state_d = ST_RUN;
                  end else begin
                     ch_idx_d = ch_idx_q + CHW'(1);
                  end
               end
            end
            ST_RUN: begin
               cnt_d       = '0;
               seq_rst_n_d = '1;
            end
            default: begin
               state_d     = ST_ASSERT;
               cnt_d       = '0;
               ch_idx_d    = '0;
               seq_rst_n_d = '0;
            end
         endcase
      end
   end

`ifdef RST_SEQ_SW_RST_EN
   logic [NUM_CH-1:0] sw_act_q, sw_act_d;
   logic [CW-1:0]     sw_cnt_q [NUM_CH];
   logic [CW-1:0]     sw_cnt_d [NUM_CH];

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         sw_act_d[i] = sw_act_q[i];
         sw_cnt_d[i] = sw_cnt_q[i];
         if (ext_rst_sync || state_q != ST_RUN) begin
            sw_act_d[i] = 1'b0;
            sw_cnt_d[i] = '0;
         end else if (sw_rst_req[i]) begin
            sw_act_d[i] = 1'b1;
            sw_cnt_d[i] = '0;
         end else if (sw_act_q[i]) begin
            sw_cnt_d[i] = sat_inc(sw_cnt_q[i]);
            if (sat_inc(sw_cnt_q[i]) == STRETCH_V) begin
               sw_act_d[i] = 1'b0;
               sw_cnt_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge sys_clk_25m) begin
      if (reset) begin
         sw_act_q <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            sw_cnt_q[i] <= '0;
         end
      end else begin
         sw_act_q <= sw_act_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            sw_cnt_q[i] <= sw_cnt_d[i];
         end
      end
   end

   assign sw_hold = sw_act_d;
`else
   logic unused_sw_rst_req;
   assign unused_sw_rst_req = ^sw_rst_req;
   assign sw_hold           = '0;
`endif

   always_comb begin
      rst_n_d    = seq_rst_n_d & ~sw_hold;
      rst_done_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (&rst_n_d);
   end

   always_ff @(posedge sys_clk_25m) begin
      if (reset) begin
         state_q    <= ST_ASSERT;
         cnt_q      <= '0;
         ch_idx_q   <= '0;
         rst_n_q    <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_idx_q   <= ch_idx_d;
         rst_n_q    <= rst_n_d;
         rst_done_q <= rst_done_d;
      end
   end

   assign rst_n_ch = rst_n_q;
   assign rst_done = rst_done_q;
   assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: two instances (stagger 3 and stagger 0),
// expected values written per edge from hand-derived timelines.
module tb_rst_seq_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       ext;
   logic [2:0] sw;

   logic [2:0] rst_n3, rst_n0;
   logic       done3, done0, busy3, busy0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          edge_n = 0;

   always #5 clk = ~clk;

   rst_seq_gen #(
      .NUM_CH      (3),
      .SYNC_STAGES (2),
      .STRETCH_CYC (4),
      .STAGGER_CYC (3)
   ) dut (
      .sys_clk_25m (clk),
      .reset       (reset),
      .ext_rst_req (ext),
      .sw_rst_req  (sw),
      .rst_n_ch    (rst_n3),
      .rst_done    (done3),
      .busy        (busy3)
   );

   rst_seq_gen #(
      .NUM_CH      (3),
      .SYNC_STAGES (2),
      .STRETCH_CYC (4),
      .STAGGER_CYC (0)
   ) dut0 (
      .sys_clk_25m (clk),
      .reset       (reset),
      .ext_rst_req (ext),
      .sw_rst_req  (sw),
      .rst_n_ch    (rst_n0),
      .rst_done    (done0),
      .busy        (busy0)
   );

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ext   = 1'b0;
      sw    = '0;
      repeat (3) step();
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_reset();
      logic [4:0] got, exp;
      reset = 1'b1;
      ext   = 1'b0;
      sw    = '0;
      repeat (3) step();
      exp = 5'b000_0_1;
      got = {rst_n3, done3, busy3};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset_state dut3: got %b want %b", got, exp);
      end
      got = {rst_n0, done0, busy0};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset_state dut0: got %b want %b", got, exp);
      end
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_release();
      logic [4:0] got, exp;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         step();
         exp = {(k >= 12), (k >= 9), (k >= 6), (k >= 13), (k < 12)};
         got = {rst_n3, done3, busy3};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL release e%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_ext_pulse();
      logic [4:0] got, exp;
      do_reset();
      for (int k = 1; k <= 22; k++) begin
         ext = (k == 8);
         step();
         exp = {(k >= 20), (k == 9 || k >= 17), ((k >= 6 && k < 10) || k >= 14),
                (k >= 21), (k < 20)};
         got = {rst_n3, done3, busy3};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL ext_pulse e%0d: got %b want %b", k, got, exp);
         end
      end
      ext = 1'b0;
   endtask

   task automatic test_stagger0();
      logic [4:0] got, exp;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step();
         exp = {{3{k >= 6}}, (k >= 7), (k < 6)};
         got = {rst_n0, done0, busy0};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL stagger0 e%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_sw_ignored_in_seq();
      logic [4:0] got, exp;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         sw = (k <= 12) ? 3'b111 : 3'b000;
         step();
         exp = {(k >= 12), (k >= 9), (k >= 6), (k >= 13), (k < 12)};
         got = {rst_n3, done3, busy3};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL sw_in_seq e%0d: got %b want %b", k, got, exp);
         end
      end
      sw = '0;
   endtask

   task automatic test_sw_pulse();
      logic [4:0] got, exp;
      logic       low;
      do_reset();
      for (int k = 1; k <= 27; k++) begin
         sw = (k == 14 || k == 20 || k == 22) ? 3'b010 : 3'b000;
         step();
         if (k >= 13) begin
`ifdef RST_SEQ_SW_RST_EN
            low = (k >= 14 && k <= 17) || (k >= 20 && k <= 25);
`else
            low = 1'b0;
`endif
            exp = {1'b1, ~low, 1'b1, ~low, 1'b0};
            got = {rst_n3, done3, busy3};
            n_vec++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL sw_pulse e%0d: got %b want %b", k, got, exp);
            end
         end
      end
      sw = '0;
   endtask

   task automatic test_sw_with_ext();
      logic [4:0] got, exp;
      do_reset();
      for (int k = 1; k <= 28; k++) begin
         ext = (k == 14);
         sw  = (k == 16) ? 3'b010 : 3'b000;
         step();
         if (k >= 13) begin
            exp = {(k < 16 || k >= 26), (k < 16 || k >= 23), (k < 16 || k >= 20),
                   (k < 16 || k >= 27), (k >= 16 && k < 26)};
            got = {rst_n3, done3, busy3};
            n_vec++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL sw_with_ext e%0d: got %b want %b", k, got, exp);
            end
         end
      end
      ext = 1'b0;
      sw  = '0;
   endtask

   task automatic test_reset_mid_release();
      logic [4:0] got, exp;
      do_reset();
      repeat (8) step();
      reset = 1'b1;
      step();
      exp = 5'b000_0_1;
      got = {rst_n3, done3, busy3};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset_mid: got %b want %b", got, exp);
      end
      reset  = 1'b0;
      edge_n = 0;
      for (int k = 1; k <= 14; k++) begin
         step();
         exp = {(k >= 12), (k >= 9), (k >= 6), (k >= 13), (k < 12)};
         got = {rst_n3, done3, busy3};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_mid_seq e%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      ext   = 1'b0;
      sw    = '0;
      test_reset();
      test_release();
      test_ext_pulse();
      test_stagger0();
      test_sw_ignored_in_seq();
      test_sw_pulse();
      test_sw_with_ext();
      test_reset_mid_release();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
